// File: rtl/imem_loader.sv
// Instruction-memory image loader: unpacks a framed byte stream into 32-bit words,
// writes them to sequential word addresses and holds the core in reset until the checksum passes.
module imem_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  // Counter width covers both the address range and the full 8-bit LEN byte.
  localparam int unsigned CW  = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [CW:0]   CAP = {{CW{1'b0}}, 1'b1} << ADDR_W;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state, r_state_n;
  logic [CW-1:0]       r_len, r_len_n;
  logic [CW-1:0]       r_wcnt, r_wcnt_n;
  logic [1:0]          r_idx, r_idx_n;
  logic [7:0]          r_csum, r_csum_n;
  logic [23:0]         r_word, r_word_n;
  logic                r_we, r_we_n;
  logic [ADDR_W-1:0]   r_addr, r_addr_n;
  logic [31:0]         r_wdata, r_wdata_n;
  logic                r_core_rst, r_core_rst_n;
  logic                r_done, r_done_n;
  logic                r_error, r_error_n;

  logic                w_accept;
  logic                w_is_hdr;
  logic [CW:0]         w_len_ext;
  logic                w_len_bad;
  logic                w_last_word;

  assign rx_ready    = !rst;
  assign w_accept    = rx_valid && rx_ready;
  assign w_is_hdr    = (rx_data == HDR);
  assign w_len_ext   = {{(CW + 1 - 8){1'b0}}, rx_data};
  assign w_len_bad   = (rx_data == 8'd0) || (w_len_ext > CAP);
  assign w_last_word = (r_wcnt == (r_len - ONE));

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_wcnt     <= '0;
      r_idx      <= '0;
      r_csum     <= '0;
      r_word     <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= r_state_n;
      r_len      <= r_len_n;
      r_wcnt     <= r_wcnt_n;
      r_idx      <= r_idx_n;
      r_csum     <= r_csum_n;
      r_word     <= r_word_n;
      r_we       <= r_we_n;
      r_addr     <= r_addr_n;
      r_wdata    <= r_wdata_n;
      r_core_rst <= r_core_rst_n;
      r_done     <= r_done_n;
      r_error    <= r_error_n;
    end
  end

  always_comb begin
    r_state_n    = r_state;
    r_len_n      = r_len;
    r_wcnt_n     = r_wcnt;
    r_idx_n      = r_idx;
    r_csum_n     = r_csum;
    r_word_n     = r_word;
    r_we_n       = 1'b0;
    r_addr_n     = r_addr;
    r_wdata_n    = r_wdata;
    r_core_rst_n = r_core_rst;
    r_done_n     = r_done;
    r_error_n    = r_error;

    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_hdr) r_state_n = S_LEN;
      end

      S_LEN: begin
        if (w_accept) begin
          if (w_len_bad) begin
            r_state_n = S_ERR;
            r_error_n = 1'b1;
          end else begin
            r_len_n   = w_len_ext[CW-1:0];
            r_wcnt_n  = '0;
            r_idx_n   = '0;
            r_csum_n  = '0;
            r_state_n = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (w_accept) begin
          r_csum_n = r_csum ^ rx_data;
          r_idx_n  = r_idx + 2'd1;
          case (r_idx)
            2'd0: r_word_n[7:0]   = rx_data;
            2'd1: r_word_n[15:8]  = rx_data;
            2'd2: r_word_n[23:16] = rx_data;
            default: begin
              // The top lane goes straight into the write word; no need to store it.
              r_we_n    = 1'b1;
              r_addr_n  = r_wcnt[ADDR_W-1:0];
              r_wdata_n = {rx_data, r_word};
              r_wcnt_n  = r_wcnt + ONE;
              if (w_last_word) r_state_n = S_CSUM;
            end
          endcase
        end
      end

      S_CSUM: begin
        if (w_accept) begin
          if (rx_data == r_csum) begin
            r_state_n    = S_DONE;
            r_done_n     = 1'b1;
            r_core_rst_n = 1'b0;
          end else begin
            r_state_n = S_ERR;
            r_error_n = 1'b1;
          end
        end
      end

      S_DONE: begin
        if (w_accept && w_is_hdr) begin
          r_state_n    = S_LEN;
          r_done_n     = 1'b0;
          r_core_rst_n = 1'b1;
        end
      end

      S_ERR: begin
        if (w_accept && w_is_hdr) begin
          r_state_n = S_LEN;
          r_error_n = 1'b0;
        end
      end

      default: begin
        r_state_n    = S_IDLE;
        r_core_rst_n = 1'b1;
        r_done_n     = 1'b0;
      end
    endcase
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_rst   = r_core_rst;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Loads a program image into the single-cycle RISC-V core's instruction memory, acting as the memory's write port against the core's read port. It accepts a framed byte stream on a valid/ready interface, packs bytes into 32-bit little-endian words and writes them to sequential word addresses. It holds the core in reset until the image is fully loaded and its checksum verified. It sits beside `top`, between the host/serial byte source and the instruction memory, and drives the core's reset.

Parameters:
ADDR_W, 6, instruction-memory word-address width; capacity is 2^ADDR_W words.
HDR, 8'hA5, frame start byte.

Ports:
CLK  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
rx_valid  input  1  byte-source valid.
rx_data  input  8  byte from source.
rx_ready  output  1  loader can accept a byte.
imem_we  output  1  one-cycle instruction-memory write strobe.
imem_addr  output  ADDR_W  word address of the write.
imem_wdata  output  32  instruction word.
core_rst  output  1  reset to the core; high while not loaded.
done  output  1  image loaded and checksum good.
error  output  1  frame error latched.

Behaviour:
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, error=0, state=IDLE, all counters and checksum cleared.
- rx_ready=1 in every state whenever rst is low. A byte is accepted only on a cycle with rx_valid && rx_ready.
- Frame format: HDR, LEN (word count, 1..2^ADDR_W), LEN×4 payload bytes (LSB first per word), CSUM. CSUM is the XOR of the payload bytes only.
- State machine:
  - IDLE: accepted byte == HDR -> LEN. Other bytes are ignored.
  - LEN: LEN==0 or LEN>2^ADDR_W -> ERR. Otherwise latch LEN, clear the word counter, byte index and checksum -> DATA.
  - DATA: each accepted byte goes into lane [8*idx +: 8] and the checksum XORs in the byte. When the 4th byte of a word is accepted:
    - On the next cycle, imem_we=1 for exactly 1 cycle, imem_addr=word counter, imem_wdata=assembled word.
    - The word counter increments.
    - After word LEN-1 -> CSUM.
  - CSUM: byte == checksum -> DONE. Mismatch -> ERR.
  - DONE: done=1, core_rst=0. An accepted HDR -> LEN with done=0 and core_rst=1 on the next edge (reload). Other bytes are ignored.
  - ERR: error=1, core_rst=1, done=0. An accepted HDR -> LEN and clears error. Other bytes are ignored.
- core_rst is registered and is 1 in every state except DONE.
- Words written before an error remain in memory. No rollback.
- A HDR value appearing inside DATA, LEN or CSUM is treated as ordinary data. There is no resync mid-frame.
- Address wrap cannot occur because LEN is bounded. For ADDR_W≥8 the LEN byte (max 255) is the only limit.
- rst asserted mid-frame aborts immediately to reset values. A partial word is discarded and imem_we is not pulsed.
- Latency: imem_we follows the 4th byte handshake by exactly 1 cycle. done/core_rst change 1 cycle after the CSUM handshake.

Test Plan:
- Good 2-word load: stream A5,02,B3,81,11,40,33,22,31,00,43 at one byte per cycle -> imem writes (0,0x401181B3) and (1,0x00312233), each imem_we 1 cycle. done=1 and core_rst=0 one cycle after the 0x43 byte.
- Bad checksum: same frame ending in 0x42 instead of 0x43 -> both words written, error=1, core_rst stays 1, done=0. Then a full good frame -> error=0, done=1.
- Length bounds: A5,00 -> ERR. A5,41 with ADDR_W=6 -> ERR with no imem_we. A5,40 followed by 256 bytes and the correct CSUM -> last write at address 63, done=1.
- Gaps and noise: bytes 00,FF before A5 are ignored. rx_valid toggling every other cycle mid-payload -> same writes as the back-to-back case.
- Reload from DONE: after a good load, send A5 -> core_rst=1 and done=0 on the next edge. A second image overwrites from address 0.
- Async reset mid-word: assert rst between the 2nd and 3rd byte of word 0 -> outputs go to reset values immediately, no imem_we. A later good frame loads correctly.
